// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with mid-bit sampling and FIFO-full-aware delivery.
// Optional stop-bit checking with frameErr strobe: define UART_RX_FRAME_CHECK_EN.
module uart_byte_rx #(
  parameter int unsigned BAUD_CYCLE = 868
) (
  input  logic       clk,
  input  logic       rstB,
  input  logic       rx,
  input  logic       FfFull,
  output logic       dataEn,
  output logic [7:0] dataOut,
  output logic       frameErr
);

  localparam int unsigned CNT_W = $clog2(BAUD_CYCLE);
  localparam int unsigned HALF  = BAUD_CYCLE / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_sh;
  logic             r_data_en;
  logic [7:0]       r_data_out;

  logic w_fall;
  logic w_cnt_full;
  logic w_cnt_half;
  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_idx_inc;
  logic w_shift;
  logic w_deliver;
`ifdef UART_RX_FRAME_CHECK_EN
  logic w_ferr;
  logic r_frame_err;
`endif

  assign w_fall     = r_prev & ~r_sync2;
  assign w_cnt_full = (r_cnt == CNT_W'(BAUD_CYCLE - 1));
  assign w_cnt_half = (r_cnt == CNT_W'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rstB) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_shift     = 1'b0;
    w_deliver   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    w_ferr      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_cnt_half) begin
          w_cnt_clr = 1'b1;
          w_idx_clr = 1'b1;
          w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_full) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_inc   = 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so the next start edge is never missed.
        if (w_cnt_full) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
          w_deliver = r_sync2 & ~FfFull;
          w_ferr    = ~r_sync2;
`else
          w_deliver = ~FfFull;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstB) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prev     <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh       <= '0;
      r_data_en  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_shift) r_sh <= {r_sync2, r_sh[7:1]};
      r_data_en <= w_deliver;
      if (w_deliver) r_data_out <= r_sh;
    end
  end

`ifdef UART_RX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rstB) r_frame_err <= 1'b0;
    else      r_frame_err <= w_ferr;
  end
  assign frameErr = r_frame_err;
`else
  assign frameErr = 1'b0;
`endif

  assign dataEn  = r_data_en;
  assign dataOut = r_data_out;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: a BAUD_CYCLE=16 instance for the main scenarios and a
// BAUD_CYCLE=868 instance for the default-rate smoke frame.
module tb_uart_byte_rx;

  localparam int unsigned B  = 16;
  localparam int unsigned BS = 868;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstB = 1'b1;
  logic       rx = 1'b1;
  logic       rx_s = 1'b1;
  logic       FfFull = 1'b0;
  logic       dataEn, frameErr, dataEn_s, frameErr_s;
  logic [7:0] dataOut, dataOut_s;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  byte unsigned got_q[$];
  int unsigned  got_cyc[$];
  byte unsigned got_s[$];
  int unsigned  ferr_cnt = 0;
  int unsigned  ferr_s_cnt = 0;

  byte unsigned exp_q[$];
  byte unsigned exp_s[$];
  int unsigned  exp_ferr = 0;
  byte unsigned exp_dout = 8'h00;

  uart_byte_rx #(.BAUD_CYCLE(B)) dut (
    .clk(clk), .rstB(rstB), .rx(rx), .FfFull(FfFull),
    .dataEn(dataEn), .dataOut(dataOut), .frameErr(frameErr)
  );

  uart_byte_rx #(.BAUD_CYCLE(BS)) dut_slow (
    .clk(clk), .rstB(rstB), .rx(rx_s), .FfFull(1'b0),
    .dataEn(dataEn_s), .dataOut(dataOut_s), .frameErr(frameErr_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dataEn === 1'b1) begin
      got_q.push_back(dataOut);
      got_cyc.push_back(cyc);
    end
    if (frameErr === 1'b1) ferr_cnt++;
    if (dataEn_s === 1'b1) got_s.push_back(dataOut_s);
    if (frameErr_s === 1'b1) ferr_s_cnt++;
  end

  // Reference model: what a receiver should hand over for a given line waveform.
  function automatic byte unsigned line_value(input logic [9:0] line);
    int unsigned v = 0;
    for (int i = 1; i <= 8; i++) v += line[i] ? (1 << (i - 1)) : 0;
    return byte'(v);
  endfunction

  function automatic bit will_deliver(input bit stop, input bit full);
    return !full && (stop || !CHECK);
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    got_q.delete(); got_cyc.delete(); got_s.delete();
    exp_q.delete(); exp_s.delete();
    ferr_cnt = 0; ferr_s_cnt = 0; exp_ferr = 0;
  endtask

  task automatic do_reset();
    rx = 1'b1; rx_s = 1'b1;
    rstB = 1'b1;
    tick(2);
    rstB = 1'b0;
    tick(2);
    clear_all();
    exp_dout = 8'h00;
  endtask

  task automatic send_frame(input byte unsigned d, input bit stop, input bit slow,
                            output int unsigned t0);
    logic [9:0] f;
    int unsigned bl;
    f  = {stop, d, 1'b0};
    bl = slow ? BS : B;
    t0 = cyc + 1;
    if (slow) begin
      exp_s.push_back(line_value(f));
    end else begin
      if (will_deliver(stop, FfFull)) begin
        exp_q.push_back(line_value(f));
        exp_dout = line_value(f);
      end
      if (CHECK && !stop) exp_ferr++;
    end
    for (int i = 0; i < 10; i++) begin
      if (slow) rx_s = f[i];
      else      rx   = f[i];
      tick(bl);
    end
  endtask

  task automatic test_reset();
    rstB = 1'b1; rx = 1'b1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      rx = ~rx;
      @(negedge clk);
      n_cmp++;
      if ({dataEn, dataOut, frameErr} !== 10'h000) begin
        n_err++;
        $display("FAIL reset_outputs: got en=%b out=%h ferr=%b expected 0/00/0", dataEn, dataOut, frameErr);
      end
      tick(1);
    end
    rx = 1'b1; rstB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dataEn !== 1'b0 || frameErr !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_strobe: got en=%b ferr=%b expected 0/0", dataEn, frameErr);
      end
      tick(1);
    end
    tick(4);
    clear_all();
  endtask

  task automatic test_single();
    int unsigned t0, lat;
    send_frame(8'hA5, 1'b1, 1'b0, t0);
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL single_count: got %0d strobes expected 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== 8'hA5) begin
        n_err++;
        $display("FAIL single_data: got %h expected a5", got_q[0]);
      end
      lat = got_cyc[0] - t0;
      n_cmp++;
      if (lat < 3 + B / 2 + 9 * B + 1 - 2 || lat > 3 + B / 2 + 9 * B + 1 + 2) begin
        n_err++;
        $display("FAIL single_latency: got %0d cycles expected 156 +/-2", lat);
      end
    end
    clear_all();
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    byte unsigned seq[3];
    seq = '{8'h00, 8'hFF, 8'h3C};
    foreach (seq[i]) send_frame(seq[i], 1'b1, 1'b0, t0);
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d strobes expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_q[i] !== seq[i]) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], seq[i]);
        end
      end
    end
    n_cmp++;
    if (ferr_cnt != 0) begin
      n_err++;
      $display("FAIL b2b_frameerr: got %0d pulses expected 0", ferr_cnt);
    end
    clear_all();
  endtask

  task automatic test_glitch();
    int unsigned t0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      n_err++;
      $display("FAIL glitch_nostrobe: got %0d strobes %0d errs expected 0/0", got_q.size(), ferr_cnt);
    end
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 1 || dataOut !== 8'h5A) begin
      n_err++;
      $display("FAIL glitch_recover: got %0d strobes out=%h expected 1/5a", got_q.size(), dataOut);
    end
    clear_all();
  endtask

  task automatic test_ffull();
    int unsigned t0;
    do_reset();
    FfFull = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0, t0);
    FfFull = 1'b0;
    tick(B);
    n_cmp++;
    if (got_q.size() != 0 || dataOut !== 8'h00) begin
      n_err++;
      $display("FAIL ffull_drop: got %0d strobes out=%h expected 0/00", got_q.size(), dataOut);
    end
    send_frame(8'h11, 1'b1, 1'b0, t0);
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 1 || dataOut !== 8'h11) begin
      n_err++;
      $display("FAIL ffull_resume: got %0d strobes out=%h expected 1/11", got_q.size(), dataOut);
    end
    clear_all();
  endtask

  task automatic test_frame_error();
    int unsigned t0;
    byte unsigned prev_out;
    prev_out = exp_dout;
    send_frame(8'h42, 1'b0, 1'b0, t0);
    tick(40);
    rx = 1'b1;
    tick(2 * B);
    n_cmp++;
    if (ferr_cnt != exp_ferr) begin
      n_err++;
      $display("FAIL frame_err_pulses: got %0d expected %0d", ferr_cnt, exp_ferr);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL frame_err_strobes: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    n_cmp++;
    if (dataOut !== (CHECK ? prev_out : 8'h42)) begin
      n_err++;
      $display("FAIL frame_err_data: got %h expected %h", dataOut, CHECK ? prev_out : 8'h42);
    end
    clear_all();
  endtask

  task automatic test_mid_reset();
    int unsigned t0;
    logic [7:0] partial;
    partial = 8'hC3;
    rx = 1'b0;
    tick(B);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      tick(B);
    end
    do_reset();
    send_frame(8'h81, 1'b1, 1'b0, t0);
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      n_err++;
      $display("FAIL mid_reset: got %0d strobes out=%h expected 1/81", got_q.size(), dataOut);
    end
    clear_all();
  endtask

  task automatic test_random();
    int unsigned t0;
    for (int n = 0; n < 16; n++) begin
      FfFull = ($urandom_range(0, 3) == 0);
      send_frame(byte'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), 1'b0, t0);
      FfFull = 1'b0;
      rx = 1'b1;
      tick($urandom_range(B, 3 * B));
    end
    tick(2 * B);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (ferr_cnt != exp_ferr || dataOut !== exp_dout) begin
      n_err++;
      $display("FAIL random_tail: got errs=%0d out=%h expected %0d/%h", ferr_cnt, dataOut, exp_ferr, exp_dout);
    end
    clear_all();
  endtask

  task automatic test_slow_smoke();
    int unsigned t0;
    send_frame(8'h55, 1'b1, 1'b1, t0);
    tick(16);
    n_cmp++;
    if (got_s.size() != 1 || dataOut_s !== exp_s[0] || ferr_s_cnt != 0) begin
      n_err++;
      $display("FAIL slow_smoke: got %0d strobes out=%h errs=%0d expected 1/55/0", got_s.size(), dataOut_s, ferr_s_cnt);
    end
    clear_all();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_ffull();
    test_frame_error();
    test_mid_reset();
    test_random();
    test_slow_smoke();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
